// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with fetch/execute FSM
// Tracks the PC, issues fetches, resolves branches/jumps and counts retirements.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_eq_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  input  logic [31:0] offset_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid_o,
  output logic        redirect_o,
  output logic        misalign_o,
  output logic [31:0] retired_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;

  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        next_is_redirect;

  assign pc_plus4_o    = pc_q + 32'd4;
  assign branch_taken  = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
  assign branch_target = pc_plus4_o + {offset_i[30:0], 1'b0};

  always_comb begin
    next_pc          = pc_plus4_o;
    next_is_redirect = 1'b0;
    if (jump_i) begin
      next_pc          = jump_target_i;
      next_is_redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc          = branch_target;
      next_is_redirect = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retired_d  = retired_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem_ack_i) state_d = EXEC;
      EXEC: begin
        // Control inputs only matter on the cycle the instruction completes.
        if (!stall_i) begin
          pc_d       = next_pc;
          retired_d  = retired_q + 32'd1;
          redirect_d = next_is_redirect;
          if (next_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            state_d = FETCH;
          end
        end
      end
      TRAP:  state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      retired_q  <= 32'd0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_o    = (state_q == FETCH);
  assign fetch_valid_o = (state_q == EXEC);
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign redirect_o    = redirect_q;
  assign misalign_o    = misalign_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_eq_i = 1'b0;
  logic        branch_ne_i = 1'b0;
  logic        zero_i = 1'b0;
  logic [31:0] offset_i = 32'd0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = 32'd0;
  logic        imem_ack_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        redirect_o;
  logic        misalign_o;
  logic [31:0] retired_o;

  int passed = 0;
  int total  = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .branch_eq_i(branch_eq_i), .branch_ne_i(branch_ne_i), .zero_i(zero_i),
    .offset_i(offset_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .imem_ack_i(imem_ack_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fetch_valid_o(fetch_valid_o),
    .redirect_o(redirect_o), .misalign_o(misalign_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 8 && !imem_req_o; i++) step();
    if (!imem_req_o) begin
      total++;
      $display("FAIL wait_fetch: imem_req_o=%0b required 1 within 8 cycles", imem_req_o);
    end
  endtask

  task automatic exec_instr(input logic j, input logic [31:0] tgt, input logic beq,
                            input logic bne, input logic z, input logic [31:0] off);
    wait_fetch();
    imem_ack_i = 1'b1;
    step();
    imem_ack_i = 1'b0;
    jump_i = j; jump_target_i = tgt; branch_eq_i = beq; branch_ne_i = bne;
    zero_i = z; offset_i = off;
    step();
    jump_i = 1'b0; jump_target_i = 32'd0; branch_eq_i = 1'b0; branch_ne_i = 1'b0;
    zero_i = 1'b0; offset_i = 32'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    imem_ack_i = 1'b1;
    step();
    step();
    imem_ack_i = 1'b0;
    total++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else passed++;
    total++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else passed++;
    total++; if (fetch_valid_o !== 1'b0) $display("FAIL reset_fv: got %b want 0", fetch_valid_o); else passed++;
    total++; if (redirect_o !== 1'b0) $display("FAIL reset_redir: got %b want 0", redirect_o); else passed++;
    total++; if (misalign_o !== 1'b0) $display("FAIL reset_mis: got %b want 0", misalign_o); else passed++;
    total++; if (retired_o !== 32'd0) $display("FAIL reset_ret: got %0d want 0", retired_o); else passed++;
    total++; if (pc_plus4_o !== 32'd4) $display("FAIL reset_pc4: got %h want 4", pc_plus4_o); else passed++;
    rst_i = 1'b0;
    step();
    total++; if (imem_req_o !== 1'b1) $display("FAIL reset_exit_fetch: got %b want 1", imem_req_o); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    wait_fetch();
    total++; if (imem_addr_o !== 32'h0) $display("FAIL seq_addr0: got %h want 0", imem_addr_o); else passed++;
    for (int i = 0; i < 4; i++) begin
      exec_instr(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      exp_pc = 32'd4 * (i + 1);
      total++; if (pc_o !== exp_pc) $display("FAIL seq_pc%0d: got %h want %h", i, pc_o, exp_pc); else passed++;
      total++; if (redirect_o !== 1'b0) $display("FAIL seq_redir%0d: got %b want 0", i, redirect_o); else passed++;
    end
    total++; if (retired_o !== 32'd4) $display("FAIL seq_retired: got %0d want 4", retired_o); else passed++;
  endtask

  task automatic test_branch();
    do_reset();
    exec_instr(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0);
    exec_instr(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    total++; if (pc_o !== 32'h0F4) $display("FAIL beq_taken_pc: got %h want 0f4", pc_o); else passed++;
    total++; if (redirect_o !== 1'b1) $display("FAIL beq_taken_redir: got %b want 1", redirect_o); else passed++;
    step();
    total++; if (redirect_o !== 1'b0) $display("FAIL beq_pulse_width: got %b want 0", redirect_o); else passed++;
    exec_instr(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0);
    exec_instr(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8);
    total++; if (pc_o !== 32'h104) $display("FAIL beq_not_taken_pc: got %h want 104", pc_o); else passed++;
    total++; if (redirect_o !== 1'b0) $display("FAIL beq_not_taken_redir: got %b want 0", redirect_o); else passed++;
    total++; if (retired_o !== 32'd4) $display("FAIL branch_retired: got %0d want 4", retired_o); else passed++;
  endtask

  task automatic test_priority_stall();
    do_reset();
    exec_instr(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 32'h40);
    total++; if (pc_o !== 32'h400) $display("FAIL prio_pc: got %h want 400", pc_o); else passed++;
    total++; if (redirect_o !== 1'b1) $display("FAIL prio_redir: got %b want 1", redirect_o); else passed++;
    wait_fetch();
    imem_ack_i = 1'b1;
    step();
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h800; branch_eq_i = 1'b1; zero_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc_o !== 32'h400) $display("FAIL stall_pc%0d: got %h want 400", i, pc_o); else passed++;
      total++; if (retired_o !== 32'd1) $display("FAIL stall_ret%0d: got %0d want 1", i, retired_o); else passed++;
      total++; if (fetch_valid_o !== 1'b1) $display("FAIL stall_fv%0d: got %b want 1", i, fetch_valid_o); else passed++;
    end
    stall_i = 1'b0; imem_ack_i = 1'b0; jump_i = 1'b0; jump_target_i = 32'd0;
    branch_eq_i = 1'b0; zero_i = 1'b0;
    step();
    total++; if (pc_o !== 32'h404) $display("FAIL stall_release_pc: got %h want 404", pc_o); else passed++;
    total++; if (retired_o !== 32'd2) $display("FAIL stall_release_ret: got %0d want 2", retired_o); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    exec_instr(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (pc_plus4_o !== 32'h0) $display("FAIL wrap_pc4: got %h want 0", pc_plus4_o); else passed++;
    exec_instr(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    total++; if (pc_o !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc_o); else passed++;
    total++; if (misalign_o !== 1'b0) $display("FAIL wrap_mis: got %b want 0", misalign_o); else passed++;
  endtask

  task automatic test_misalign();
    do_reset();
    exec_instr(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0);
    exec_instr(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd1);
    total++; if (pc_o !== 32'h16) $display("FAIL mis_pc: got %h want 16", pc_o); else passed++;
    total++; if (misalign_o !== 1'b1) $display("FAIL mis_flag: got %b want 1", misalign_o); else passed++;
    total++; if (retired_o !== 32'd2) $display("FAIL mis_ret: got %0d want 2", retired_o); else passed++;
    imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_req_o !== 1'b0) $display("FAIL trap_req%0d: got %b want 0", i, imem_req_o); else passed++;
      total++; if (fetch_valid_o !== 1'b0) $display("FAIL trap_fv%0d: got %b want 0", i, fetch_valid_o); else passed++;
    end
    total++; if (pc_o !== 32'h16) $display("FAIL trap_pc: got %h want 16", pc_o); else passed++;
    imem_ack_i = 1'b0;
    rst_i = 1'b1;
    step();
    total++; if (misalign_o !== 1'b0) $display("FAIL trap_reset_mis: got %b want 0", misalign_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL trap_reset_pc: got %h want 0", pc_o); else passed++;
    rst_i = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    exec_instr(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    wait_fetch();
    imem_ack_i = 1'b1;
    rst_i = 1'b1;
    step();
    total++; if (fetch_valid_o !== 1'b0) $display("FAIL midrst_fv: got %b want 0", fetch_valid_o); else passed++;
    total++; if (imem_req_o !== 1'b0) $display("FAIL midrst_req: got %b want 0", imem_req_o); else passed++;
    total++; if (pc_o !== 32'h0) $display("FAIL midrst_pc: got %h want 0", pc_o); else passed++;
    total++; if (retired_o !== 32'd0) $display("FAIL midrst_ret: got %0d want 0", retired_o); else passed++;
    rst_i = 1'b0;
    step();
    total++; if (fetch_valid_o !== 1'b0) $display("FAIL midrst_no_exec: got %b want 0", fetch_valid_o); else passed++;
    total++; if (imem_req_o !== 1'b1) $display("FAIL midrst_refetch: got %b want 1", imem_req_o); else passed++;
    imem_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority_stall();
    test_wrap();
    test_misalign();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
